// File: rtl/sce_rr_scheduler.sv
// sce_rr_scheduler: round-robin front end sharing one sequence-component engine.
// Optional watchdog: define SCE_SCHED_TIMEOUT_EN (sticky err, abort on stall).
module sce_rr_scheduler #(
  parameter int M       = 14,
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH*M-1:0] ch_va,
  input  logic [N_CH*M-1:0] ch_vb,
  input  logic [N_CH*M-1:0] ch_vc,
  output logic [N_CH-1:0]   ch_ack,
  output logic              eng_start,
  output logic [M-1:0]      eng_va,
  output logic [M-1:0]      eng_vb,
  output logic [M-1:0]      eng_vc,
  output logic [M-1:0]      eng_vb1,
  output logic [M-1:0]      eng_vc1,
  input  logic              eng_done,
  input  logic [M-1:0]      eng_pos,
  input  logic [M-1:0]      eng_neg,
  input  logic [M-1:0]      eng_zero,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [M-1:0]      res_pos,
  output logic [M-1:0]      res_neg,
  output logic [M-1:0]      res_zero,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] gnt_q, gnt_d;
  logic [N_CH-1:0] ack_q, ack_d;
  logic            start_q, start_d;
  logic [M-1:0]    va_q, va_d;
  logic [M-1:0]    vb_q, vb_d;
  logic [M-1:0]    vc_q, vc_d;
  logic [M-1:0]    vb1_q, vb1_d;
  logic [M-1:0]    vc1_q, vc1_d;
  logic [M-1:0]    hist_vb_q [N_CH];
  logic [M-1:0]    hist_vb_d [N_CH];
  logic [M-1:0]    hist_vc_q [N_CH];
  logic [M-1:0]    hist_vc_d [N_CH];
  logic            rv_q, rv_d;
  logic [CH_W-1:0] rch_q, rch_d;
  logic [M-1:0]    pos_q, pos_d;
  logic [M-1:0]    neg_q, neg_d;
  logic [M-1:0]    zero_q, zero_d;

`ifdef SCE_SCHED_TIMEOUT_EN
  localparam int TW =
    ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  logic            pick_vld;
  logic [CH_W-1:0] pick;
  logic [CH_W:0]   pidx;

  // Find the first requester at or after rr, wrapping at N_CH.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    pidx     = '0;
    for (int i = 0; i < N_CH; i++) begin
      pidx = {1'b0, rr_q} + (CH_W+1)'(i);
      if (pidx >= (CH_W+1)'(N_CH)) begin
        pidx = pidx - (CH_W+1)'(N_CH);
      end
      if (!pick_vld && ch_req[pidx[CH_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = pidx[CH_W-1:0];
      end
    end
  end

  // Next-state logic for the sequencer, operands, history and results.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    start_d   = 1'b0;
    va_d      = va_q;
    vb_d      = vb_q;
    vc_d      = vc_q;
    vb1_d     = vb1_q;
    vc1_d     = vc1_q;
    hist_vb_d = hist_vb_q;
    hist_vc_d = hist_vc_q;
    rv_d      = 1'b0;
    rch_d     = rch_q;
    pos_d     = pos_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
`ifdef SCE_SCHED_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          ack_d   = {{(N_CH-1){1'b0}}, 1'b1} << pick;
          start_d = 1'b1;
          va_d    = ch_va[pick*M +: M];
          vb_d    = ch_vb[pick*M +: M];
          vc_d    = ch_vc[pick*M +: M];
          vb1_d   = hist_vb_q[pick];
          vc1_d   = hist_vc_q[pick];
          state_d = S_START;
        end
      end
      S_START: begin
        if (gnt_q == CH_W'(N_CH - 1)) begin
          rr_d = '0;
        end else begin
          rr_d = gnt_q + CH_W'(1);
        end
`ifdef SCE_SCHED_TIMEOUT_EN
        wcnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef SCE_SCHED_TIMEOUT_EN
        wcnt_d = wcnt_q + TW'(1);
`endif
        if (eng_done) begin
          pos_d            = eng_pos;
          neg_d            = eng_neg;
          zero_d           = eng_zero;
          rch_d            = gnt_q;
          hist_vb_d[gnt_q] = vb_q;
          hist_vc_d[gnt_q] = vc_q;
          rv_d             = 1'b1;
          state_d          = S_DONE;
        end
`ifdef SCE_SCHED_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      va_q    <= '0;
      vb_q    <= '0;
      vc_q    <= '0;
      vb1_q   <= '0;
      vc1_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hist_vb_q[i] <= '0;
        hist_vc_q[i] <= '0;
      end
      rv_q    <= 1'b0;
      rch_q   <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      zero_q  <= '0;
`ifdef SCE_SCHED_TIMEOUT_EN
      wcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      start_q   <= start_d;
      va_q      <= va_d;
      vb_q      <= vb_d;
      vc_q      <= vc_d;
      vb1_q     <= vb1_d;
      vc1_q     <= vc1_d;
      hist_vb_q <= hist_vb_d;
      hist_vc_q <= hist_vc_d;
      rv_q      <= rv_d;
      rch_q     <= rch_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
`ifdef SCE_SCHED_TIMEOUT_EN
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign ch_ack    = ack_q;
  assign eng_start = start_q;
  assign eng_va    = va_q;
  assign eng_vb    = vb_q;
  assign eng_vc    = vc_q;
  assign eng_vb1   = vb1_q;
  assign eng_vc1   = vc1_q;
  assign res_valid = rv_q;
  assign res_ch    = rch_q;
  assign res_pos   = pos_q;
  assign res_neg   = neg_q;
  assign res_zero  = zero_q;
  assign busy      = (state_q != S_IDLE);
`ifdef SCE_SCHED_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
